// File: rtl/cache_responder.sv
// Direct-mapped, write-back, write-allocate cache of one-word lines in front of a
// slow backing memory. Hits complete in one cycle; misses run writeback/fill transfers.
module cache_responder #(
  parameter int INDEX_W  = 3,
  parameter int MEM_AW   = 8,
  parameter int MISS_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << MEM_AW;
  localparam int TAG_W = 15 - INDEX_W;
  localparam logic [3:0] LAT_LAST = 4'(MISS_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_WB      = 3'd2,
    S_FILL    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic [15:0]        addr_r, wdata_r;
  logic               rd_r;
  logic [LINES-1:0]   valid_r, dirty_r;
  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [15:0]        line_r [LINES];
  logic [15:0]        mem_r  [WORDS];

  logic               accept_s, err_s, done_s, hit_out_s;
  logic [15:0]        dout_s;
  logic               wb_write_s, fill_s, merge_s;

  logic [INDEX_W-1:0] in_idx_s, idx_s;
  logic [TAG_W-1:0]   in_tag_s, tag_s;
  logic [MEM_AW-1:0]  word_s, victim_word_s;
  logic               in_hit_s, hit_s;
  logic               addr_lsb_unused_s;

  assign addr_lsb_unused_s = Addr[0];
  assign in_idx_s      = Addr[INDEX_W:1];
  assign in_tag_s      = Addr[15:INDEX_W+1];
  assign idx_s         = addr_r[INDEX_W:1];
  assign tag_s         = addr_r[15:INDEX_W+1];
  assign word_s        = addr_r[MEM_AW:1];
  // Victim line lives at word {tag, index}, folded onto the smaller memory.
  assign victim_word_s = MEM_AW'({tag_r[idx_s], idx_s});
  assign in_hit_s      = valid_r[in_idx_s] && (tag_r[in_idx_s] == in_tag_s);
  assign hit_s         = valid_r[idx_s] && (tag_r[idx_s] == tag_s);

  // Next-state, transfer counter and next values of the registered outputs.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;
    err_s      = 1'b0;
    done_s     = 1'b0;
    hit_out_s  = 1'b0;
    dout_s     = 16'h0000;
    wb_write_s = 1'b0;
    fill_s     = 1'b0;
    merge_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (Rd ^ Wr) begin
          accept_s  = 1'b1;
          state_s   = S_COMPARE;
          done_s    = in_hit_s;
          hit_out_s = in_hit_s;
          dout_s    = (Rd && in_hit_s) ? line_r[in_idx_s] : 16'h0000;
        end else if (Rd && Wr) begin
          err_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_COMPARE: begin
        cnt_s = 4'd0;
        if (hit_s) begin
          state_s = S_IDLE;
          merge_s = !rd_r;
        end else if (valid_r[idx_s] && dirty_r[idx_s]) begin
          state_s = S_WB;
        end else begin
          state_s = S_FILL;
        end
      end
      S_WB: begin
        if (cnt_r == LAT_LAST) begin
          cnt_s      = 4'd0;
          wb_write_s = 1'b1;
          state_s    = S_FILL;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      S_FILL: begin
        if (cnt_r == LAT_LAST) begin
          cnt_s   = 4'd0;
          fill_s  = 1'b1;
          state_s = S_DONE;
          done_s  = 1'b1;
          dout_s  = rd_r ? mem_r[word_s] : 16'h0000;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        merge_s = !rd_r;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= 4'd0;
      Done     <= 1'b0;
      CacheHit <= 1'b0;
      DataOut  <= 16'h0000;
      err      <= 1'b0;
      Stall    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      Done     <= done_s;
      CacheHit <= hit_out_s;
      DataOut  <= dout_s;
      err      <= err_s;
      Stall    <= (state_s != S_IDLE);
    end
  end

  // Request capture at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      rd_r    <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= Addr;
      wdata_r <= DataIn;
      rd_r    <= Rd;
    end
  end

  // Line valid/dirty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (fill_s) begin
      valid_r[idx_s] <= 1'b1;
      dirty_r[idx_s] <= 1'b0;
    end else if (merge_s) begin
      dirty_r[idx_s] <= 1'b1;
    end
  end

  // Line tag and data; meaningless until valid, so no reset.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_r[idx_s]  <= tag_s;
      line_r[idx_s] <= mem_r[word_s];
    end else if (merge_s) begin
      line_r[idx_s] <= wdata_r;
    end
  end

  // Backing memory, cleared by reset and written only by victim writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (wb_write_s) begin
      mem_r[victim_word_s] <= line_r[idx_s];
    end
  end

endmodule

// File: tb/tb_cache_responder.sv
// Self-checking bench for cache_responder: transaction-level cache/memory model,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_cache_responder;
  localparam int INDEX_W  = 3;
  localparam int MEM_AW   = 8;
  localparam int MISS_LAT = 4;
  localparam int NLINES   = 1 << INDEX_W;
  localparam int NWORDS   = 1 << MEM_AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, CacheHit, err;

  always #5 clk = ~clk;

  cache_responder #(.INDEX_W(INDEX_W), .MEM_AW(MEM_AW), .MISS_LAT(MISS_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err)
  );

  int n_vec = 0;
  int n_bad = 0;

  bit          m_valid [NLINES];
  bit          m_dirty [NLINES];
  int          m_tag   [NLINES];
  logic [15:0] m_data  [NLINES];
  logic [15:0] m_mem   [NWORDS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NLINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < NWORDS; i++) m_mem[i] = 16'h0000;
  endtask

  // Whole-transaction prediction: latency, hit flag and read data.
  task automatic model_req(input bit rd, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output bit hit, output logic [15:0] dout);
    int idx, tag, word, vword;
    idx  = (int'(a) / 2) % NLINES;
    tag  = int'(a) / (2 * NLINES);
    word = (int'(a) / 2) % NWORDS;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      hit = 1'b1;
      lat = 1;
    end else begin
      hit = 1'b0;
      if (m_valid[idx] && m_dirty[idx]) begin
        vword = (m_tag[idx] * NLINES + idx) % NWORDS;
        m_mem[vword] = m_data[idx];
        lat = 2 * MISS_LAT + 2;
      end else begin
        lat = MISS_LAT + 2;
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_data[idx]  = m_mem[word];
    end
    dout = rd ? m_data[idx] : 16'h0000;
    if (!rd) begin
      m_data[idx]  = d;
      m_dirty[idx] = 1'b1;
    end
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_req(input bit rd, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output bit hit, output logic [15:0] dout);
    int c;
    bit seen;
    model_req(rd, a, d, lat, hit, dout);
    Rd = rd; Wr = !rd; Addr = a; DataIn = d;
    seen = 1'b0;
    for (c = 1; c <= 2 * MISS_LAT + 8; c++) begin
      @(negedge clk);
      if (Done) begin
        seen = 1'b1;
        break;
      end
      chk("busy", 32'({Stall, CacheHit, err, DataOut}), {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
      Addr = 16'($urandom);
      DataIn = 16'($urandom);
    end
    Rd = 1'b0; Wr = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", c, lat);
      chk("cachehit", 32'(CacheHit), 32'(hit));
      chk("dataout", 32'(DataOut), 32'(dout));
      chk("err_on_done", 32'(err), 32'd0);
    end
    @(negedge clk);
    chk("post_done", 32'({Done, Stall, CacheHit, err, DataOut}), 32'd0);
  endtask

  task automatic run_err(input logic [15:0] a);
    Rd = 1'b1; Wr = 1'b1; Addr = a; DataIn = 16'($urandom);
    @(negedge clk);
    chk("err_pulse", 32'({err, Stall, Done, CacheHit}), 32'b1000);
    chk("err_dout", 32'(DataOut), 32'd0);
    Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    chk("err_clear", 32'({err, Stall, Done}), 32'd0);
  endtask

  initial begin
    int lat;
    bit hit;
    logic [15:0] dout, a;
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out", 32'({Done, Stall, CacheHit, err, DataOut}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'({Stall, Done}), 32'd0);

    run_req(1'b1, 16'h0010, 16'h0000, lat, hit, dout);
    chk("pin_cold_lat", lat, 32'd6); chk("pin_cold_hit", 32'(hit), 32'd0);
    chk("pin_cold_data", 32'(dout), 32'h0000);
    run_req(1'b0, 16'h0010, 16'hBEEF, lat, hit, dout);
    chk("pin_wrhit_lat", lat, 32'd1); chk("pin_wrhit_hit", 32'(hit), 32'd1);
    run_req(1'b1, 16'h0010, 16'h0000, lat, hit, dout);
    chk("pin_rdhit_data", 32'(dout), 32'hBEEF);
    run_req(1'b1, 16'h0020, 16'h0000, lat, hit, dout);
    chk("pin_dirty_lat", lat, 32'd10); chk("pin_dirty_data", 32'(dout), 32'h0000);
    run_req(1'b1, 16'h0010, 16'h0000, lat, hit, dout);
    chk("pin_refill_lat", lat, 32'd6); chk("pin_refill_data", 32'(dout), 32'hBEEF);
    run_err(16'h0010);
    run_req(1'b1, 16'h0010, 16'h0000, lat, hit, dout);
    chk("pin_after_err", 32'({hit, dout}), {15'd0, 1'b1, 16'hBEEF});
    run_req(1'b0, 16'h0010, 16'hBEEF, lat, hit, dout);
    run_req(1'b1, 16'h0210, 16'h0000, lat, hit, dout);
    chk("pin_alias_lat", lat, 32'd10); chk("pin_alias_data", 32'(dout), 32'hBEEF);

    // Reset in the middle of a fill.
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0030;
    @(negedge clk);
    @(negedge clk);
    chk("fill_stall", 32'({Stall, Done}), 32'b10);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 32'({Stall, Done, CacheHit, err, DataOut}), 32'd0);
    model_reset();
    Rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(1'b1, 16'h0010, 16'h0000, lat, hit, dout);
    chk("pin_post_rst_lat", lat, 32'd6); chk("pin_post_rst_data", 32'(dout), 32'h0000);
    chk("pin_post_rst_hit", 32'(hit), 32'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) a = 16'($urandom) & 16'hFFFE;
      else a = 16'($urandom_range(0, 16'h07FF)) & 16'hFFFE;
      if ($urandom_range(0, 15) == 0) run_err(a);
      else run_req(1'($urandom_range(0, 1)), a, 16'($urandom), lat, hit, dout);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_responder.md
CACHE_RESPONDER -- requirements
Module: cache_responder

Interface
- REQ-001: Parameter INDEX_W, default 3: cache index width; the cache holds 2^INDEX_W one-word lines.
- REQ-002: Parameter MEM_AW, default 8: backing-memory word-address width; backing memory holds 2^MEM_AW words.
- REQ-003: Parameter MISS_LAT, default 4: cycles per backing-memory transfer (writeback or fill); legal range 1..8.
- REQ-004: clk  in  1  sole clock; all state updates on the rising edge.
- REQ-005: rst_n  in  1  asynchronous, active-low reset.
- REQ-006: Addr  in  16  byte address; Addr[0] ignored.
- REQ-007: DataIn  in  16  write data.
- REQ-008: Rd  in  1  read request.
- REQ-009: Wr  in  1  write request.
- REQ-010: DataOut  out  16  read data, valid only while Done=1 on a read.
- REQ-011: Done  out  1  one-cycle completion pulse.
- REQ-012: Stall  out  1  busy; a request is accepted only while Stall=0.
- REQ-013: CacheHit  out  1  qualifies Done: 1 = serviced as a hit.
- REQ-014: err  out  1  one-cycle pulse for an illegal request (Rd and Wr both high).

Function
- REQ-015: Address split: word = Addr[MEM_AW:1], index = Addr[INDEX_W:1], tag = Addr[15:INDEX_W+1].
- REQ-016: Backing-memory addresses alias modulo 2^MEM_AW words.
- REQ-017: Each line holds valid, dirty, tag and 16-bit data; the cache is direct-mapped, write-back and write-allocate.
- REQ-018: States: IDLE, COMPARE, WB, FILL, DONE; Stall = (state != IDLE).
- REQ-019: IDLE: on exactly one of Rd/Wr, latch Addr, DataIn and the op, then go to COMPARE on the next edge.
- REQ-020: IDLE with Rd=Wr=1: err=1 for one cycle, no latch, no state change; Done stays 0.
- REQ-021: COMPARE, hit (valid and tag match): Done=1 and CacheHit=1 in this cycle; return to IDLE.
  - read hit: DataOut = line data.
  - write hit: line data = latched DataIn and dirty=1 at the cycle-ending edge.
- REQ-022: COMPARE, miss: go to WB if the victim is valid and dirty, else to FILL.
- REQ-023: WB: count MISS_LAT cycles, then write the victim data to the memory word {victim tag, index} (aliased per REQ-016) and go to FILL.
- REQ-024: FILL: count MISS_LAT cycles, then install the memory word with valid=1, dirty=0 and the new tag; go to DONE.
- REQ-025: DONE: Done=1, CacheHit=0.
  - read: DataOut = filled data.
  - write: merge DataIn into the line, set dirty=1.
  - Return to IDLE.
- REQ-026: Latency, counted from the accept edge to the cycle Done=1:
  - hit: 1 cycle.
  - clean miss: MISS_LAT+2 cycles.
  - dirty miss: 2*MISS_LAT+2 cycles (6 and 10 at default).
- REQ-027: Done, CacheHit and err are never high outside the cases above.
- REQ-028: DataOut = 0 whenever Done=0.
- REQ-029: Inputs are not sampled while Stall=1; the requester holds Rd/Wr until Done, and Done clears the request.

Reset
- REQ-030: rst_n=0 forces, immediately and asynchronously, all of the following:
  - state = IDLE, transfer counter = 0;
  - Done = Stall = CacheHit = err = 0, DataOut = 0;
  - all line valid and dirty bits = 0;
  - all backing-memory words = 0x0000.
- REQ-031: Reset during WB, FILL or DONE abandons the transfer; the pending write and dirty line data are lost.
- REQ-032: The first edge after rst_n rises finds the block in IDLE with Stall=0.

Verification
- REQ-033: After reset, Rd 0x0010 -> miss; Done 6 cycles after accept, CacheHit=0, DataOut=0x0000.
- REQ-034: Wr 0x0010 DataIn=0xBEEF -> hit, Done next cycle, CacheHit=1; then Rd 0x0010 -> hit, DataOut=0xBEEF.
- REQ-035: Then Rd 0x0020 (same index, new tag, dirty victim) -> Done after 10 cycles, CacheHit=0, DataOut=0x0000.
  - Then Rd 0x0010 -> clean miss after 6 cycles, DataOut=0xBEEF.
- REQ-036: Rd=Wr=1 in IDLE -> err=1 for exactly one cycle, Stall=0, Done=0, cache unchanged.
- REQ-037: Wr 0x0010=0xBEEF, then Rd 0x0210 (aliases word 0x08, different tag) -> dirty miss after 10 cycles, DataOut=0xBEEF.
- REQ-038: Assert rst_n=0 during FILL of Rd 0x0030 -> Stall/Done drop without a clock; after release, Rd 0x0010 misses (CacheHit=0, DataOut=0x0000).
